// File: rtl/vehicle_detector.sv
// Purpose: synchronise/debounce a vehicle loop, count waiting cars, raise the side-road request.
// Latency: loop_raw rise -> car_pulse/queue update in 2 + DEBOUNCE_CYCLES + 1 clock edges.
// Backpressure: none; green_secondary is sampled every cycle. Queue build gated by VEHICLE_DETECTOR_QUEUE_EN.
module vehicle_detector #(
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter int PASS_CYCLES     = 48000000,
   parameter int QUEUE_MAX       = 15,
   parameter int QW              = 4   // QUEUE_MAX must fit: QUEUE_MAX < 2**QW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          loop_raw,
   input  logic          green_secondary,
   output logic          sensor,
   output logic [QW-1:0] queue,
   output logic          car_pulse,
   output logic          overflow
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW  = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;

   logic           loop_m;
   logic           loop_s;
   logic           loop_db;
   logic           loop_db_q;
   logic [DBW-1:0] db_cnt;
   logic           arrive;

   // Two-flop synchroniser for the asynchronous loop input.
   always_ff @(posedge clk) begin
      if (rst) begin
         loop_m <= 1'b0;
         loop_s <= 1'b0;
      end else begin
         loop_m <= loop_raw;
         loop_s <= loop_m;
      end
   end

   // Accept a new loop level only after it differs from loop_db for DEBOUNCE_CYCLES edges in a row.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt  <= '0;
         loop_db <= 1'b0;
      end else if (loop_s == loop_db) begin
         db_cnt <= '0;
      end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
         loop_db <= loop_s;
         db_cnt  <= '0;
      end else begin
         db_cnt <= db_cnt + DBW'(1);
      end
   end

   assign arrive = loop_db & ~loop_db_q;

   // Rising-edge detect on the debounced level; one strobe per arrival.
   always_ff @(posedge clk) begin
      if (rst) begin
         loop_db_q <= 1'b0;
         car_pulse <= 1'b0;
      end else begin
         loop_db_q <= loop_db;
         car_pulse <= arrive;
      end
   end

`ifdef VEHICLE_DETECTOR_QUEUE_EN
   logic [PW-1:0] pass_cnt;
   logic          depart;

   assign depart = green_secondary && (queue != '0) && (pass_cnt == PW'(PASS_CYCLES - 1));

   // Time one departure per PASS_CYCLES of side-road green; a partial pass is dropped with green.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass_cnt <= '0;
      end else if (!green_secondary || (queue == '0) || depart) begin
         pass_cnt <= '0;
      end else begin
         pass_cnt <= pass_cnt + PW'(1);
      end
   end

   // Queue bookkeeping; a coincident arrival and departure cancel, so saturation never flags then.
   always_ff @(posedge clk) begin
      if (rst) begin
         queue    <= '0;
         overflow <= 1'b0;
      end else if (arrive && !depart) begin
         if (queue < QW'(QUEUE_MAX)) begin
            queue <= queue + QW'(1);
         end else begin
            overflow <= 1'b1;
         end
      end else if (depart && !arrive) begin
         queue <= queue - QW'(1);
      end
   end

   assign sensor = (queue != '0);
`else
   logic unused_cfg;

   // Without the queue the request simply follows the debounced loop level.
   assign queue      = '0;
   assign overflow   = 1'b0;
   assign sensor     = loop_db;
   assign unused_cfg = green_secondary ^ (QUEUE_MAX == 0) ^ (PASS_CYCLES == 0) ^ (PW == 0);
`endif

endmodule
